// File: rtl/alarm_timer.sv
// rtl/alarm_timer.sv - countdown timer and 1 Hz time base for the alarm state machine
//
// Purpose:
//   Free-running divider that produces a one-cycle strobe once per second,
//   four reprogrammable delay registers (seconds), and a two-state countdown
//   that loads the selected delay on start_timer and pulses expired when the
//   count runs out. Sits beside the alarm FSM in the alarm top level.
//
// Build option:
//   ALARM_TIMER_BLINK_EN - when defined, blink toggles on every one-second
//   strobe (0.5 Hz square wave). When undefined, blink is tied low.
//
// Ports:
//   clock          in   1  system clock, rising edge
//   reset_n        in   1  asynchronous active-low reset
//   start_timer    in   1  load delay[interval] and start counting
//   interval       in   2  delay select, sampled only with start_timer
//   reprogram      in   1  write time_value into delay[time_param_sel], aborts a count
//   time_param_sel in   2  delay register written by reprogram
//   time_value     in   4  new delay in seconds
//   one_hz_enable  out  1  one-cycle strobe per second
//   expired        out  1  one-cycle pulse at the end of a countdown
//   running        out  1  countdown in progress
//   seconds_left   out  4  remaining seconds, 0 when idle
//   blink          out  1  0.5 Hz square wave (build option)

module alarm_timer #(
  parameter int CYCLES_PER_SEC = 50_000_000,
  parameter int T_ARM_DELAY    = 6,
  parameter int T_DRIVER_DELAY = 8,
  parameter int T_PASS_DELAY   = 15,
  parameter int T_ALARM_ON     = 10
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start_timer,
  input  logic [1:0] interval,
  input  logic       reprogram,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  output logic       one_hz_enable,
  output logic       expired,
  output logic       running,
  output logic [3:0] seconds_left,
  output logic       blink
);

  localparam int DIV_W = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CYCLES_PER_SEC - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  logic [DIV_W-1:0] r_div;
  logic             w_tick;
  logic             w_start_accept;

  logic [3:0]       r_delay [0:3];

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_secs;
  logic [3:0]       w_secs_nxt;
  logic             r_expired;
  logic             w_expired_nxt;

  // reprogram outranks start_timer, so a start in a reprogram cycle is
  // neither loaded nor allowed to realign the divider.
  assign w_start_accept = start_timer & ~reprogram;
  assign w_tick         = (r_div == DIV_MAX);

  // Divider: realigned on an accepted start so the first tick lands exactly
  // one full second after the start, regardless of the previous phase.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= '0;
    end else if (w_start_accept || w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Delay registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_delay[0] <= 4'(T_ARM_DELAY);
      r_delay[1] <= 4'(T_DRIVER_DELAY);
      r_delay[2] <= 4'(T_PASS_DELAY);
      r_delay[3] <= 4'(T_ALARM_ON);
    end else if (reprogram) begin
      r_delay[time_param_sel] <= time_value;
    end
  end

  // Countdown FSM: state and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_secs    <= 4'd0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_secs    <= w_secs_nxt;
      r_expired <= w_expired_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_secs_nxt    = r_secs;
    w_expired_nxt = 1'b0;

    if (reprogram) begin
      // Abort without an expiry pulse; the FSM will restart explicitly.
      w_state_nxt = S_IDLE;
      w_secs_nxt  = 4'd0;
    end else if (start_timer) begin
      // Valid from either state; a start on the final tick wins over expiry.
      w_state_nxt = S_RUN;
      w_secs_nxt  = r_delay[interval];
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_tick) begin
            // A loaded 0 takes the <=1 branch, so it behaves as a 1 s delay
            // and the count never wraps below zero.
            if (r_secs > 4'd1) begin
              w_secs_nxt = r_secs - 4'd1;
            end else begin
              w_secs_nxt    = 4'd0;
              w_expired_nxt = 1'b1;
              w_state_nxt   = S_IDLE;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign one_hz_enable = w_tick;
  assign expired       = r_expired;
  assign running       = (r_state == S_RUN);
  assign seconds_left  = r_secs;

`ifdef ALARM_TIMER_BLINK_EN
  logic r_blink;

  // Free-running toggle, independent of the countdown state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_blink <= 1'b0;
    end else if (w_tick) begin
      r_blink <= ~r_blink;
    end
  end

  assign blink = r_blink;
`else
  assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_timer.sv
// tb/tb_alarm_timer.sv - scoreboard testbench for alarm_timer
module tb_alarm_timer;

  localparam int CPS = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start_timer = 1'b0;
  logic [1:0] interval = 2'd0;
  logic       reprogram = 1'b0;
  logic [1:0] time_param_sel = 2'd0;
  logic [3:0] time_value = 4'd0;
  logic       one_hz_enable;
  logic       expired;
  logic       running;
  logic [3:0] seconds_left;
  logic       blink;

  always #5 clock = ~clock;

  alarm_timer #(.CYCLES_PER_SEC(CPS)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start_timer    (start_timer),
    .interval       (interval),
    .reprogram      (reprogram),
    .time_param_sel (time_param_sel),
    .time_value     (time_value),
    .one_hz_enable  (one_hz_enable),
    .expired        (expired),
    .running        (running),
    .seconds_left   (seconds_left),
    .blink          (blink)
  );

  typedef struct {
    bit one_hz;
    bit ex;
    bit run;
    int secs;
    bit blk;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  bit started = 0;

  // Reference model: absolute-time view. A start at edge s with delay d
  // expires at edge s + CPS*max(d,1); seconds tick every CPS edges from the
  // last divider realignment (reset or accepted start).
  int n = 0;
  int base = 0;
  int start_edge = 0;
  int deadline = 0;
  int dval = 0;
  bit m_run = 0;
  bit m_blink = 0;
  int dly[4] = '{6, 8, 15, 10};

  int exp_count = 0;
  int last_exp_edge = -1000;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, req, n);
    end
  endtask

  task automatic step(input bit st, input int iv, input bit rp, input int sel, input int val);
    int   e;
    bit   tick;
    bit   ex;
    exp_t x;
    @(negedge clock);
    reset_n        = 1'b1;
    start_timer    = st;
    interval       = 2'(iv);
    reprogram      = rp;
    time_param_sel = 2'(sel);
    time_value     = 4'(val);
    e    = n + 1;
    tick = ((e - base) % CPS) == 0;
    ex   = 0;
    if (tick) m_blink = ~m_blink;
    if (rp) begin
      dly[sel] = val;
      m_run    = 0;
    end else if (st) begin
      m_run      = 1;
      dval       = dly[iv];
      start_edge = e;
      deadline   = e + CPS * ((dval == 0) ? 1 : dval);
      base       = e;
    end else if (m_run && e == deadline) begin
      m_run = 0;
      ex    = 1;
    end
    x.one_hz = ((e - base) % CPS) == (CPS - 1);
    x.ex     = ex;
    x.run    = m_run;
    x.secs   = m_run ? (dval - (e - start_edge) / CPS) : 0;
`ifdef ALARM_TIMER_BLINK_EN
    x.blk    = m_blink;
`else
    x.blk    = 1'b0;
`endif
    exp_q.push_back(x);
    started = 1;
    @(posedge clock);
    n = e;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    int   e;
    exp_t x;
    @(negedge clock);
    reset_n     = 1'b0;
    start_timer = 1'b0;
    reprogram   = 1'b0;
    #1;
    check("rst_running", running, 0);
    check("rst_seconds_left", seconds_left, 0);
    check("rst_expired", expired, 0);
    check("rst_one_hz", one_hz_enable, 0);
    check("rst_blink", blink, 0);
    dly     = '{6, 8, 15, 10};
    m_run   = 0;
    m_blink = 0;
    e       = n + 1;
    base    = e;
    x.one_hz = 0; x.ex = 0; x.run = 0; x.secs = 0; x.blk = 0;
    exp_q.push_back(x);
    @(posedge clock);
    n = e;
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare it
  // against the oldest scoreboard entry.
  initial begin
    exp_t x;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("one_hz_enable", one_hz_enable, x.one_hz);
        check("expired", expired, x.ex);
        check("running", running, x.run);
        check("seconds_left", seconds_left, x.secs);
        check("blink", blink, x.blk);
        if (expired) begin
          exp_count++;
          last_exp_edge = n;
        end
      end else if (started) begin
        check("scoreboard_underrun", 1, 0);
      end
    end
  end

  initial begin
    int s;
    int s2;
    int cnt0;
    int r;

    // Reset state while held in reset
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("init_running", running, 0);
    check("init_seconds_left", seconds_left, 0);
    check("init_expired", expired, 0);
    check("init_one_hz", one_hz_enable, 0);
    check("init_blink", blink, 0);

    // Default driver delay: expiry 32 cycles after start
    step(1, 1, 0, 0, 0); s = n;
    idle(36);
    check("lat_driver_8s", last_exp_edge - s, 32);

    // Reprogrammed delays 2 s and 0 s
    step(0, 0, 1, 3, 2);
    step(1, 3, 0, 0, 0); s = n;
    idle(12);
    check("lat_prog_2s", last_exp_edge - s, 8);
    step(0, 0, 1, 3, 0);
    step(1, 3, 0, 0, 0); s = n;
    idle(8);
    check("lat_prog_0s", last_exp_edge - s, 4);

    // Restart mid-count with a different interval
    cnt0 = exp_count;
    step(1, 2, 0, 0, 0);
    idle(19);
    step(1, 0, 0, 0, 0); s = n;
    idle(30);
    check("lat_restart", last_exp_edge - s, 24);
    check("restart_pulses", exp_count - cnt0, 1);

    // Reprogram mid-count aborts silently
    cnt0 = exp_count;
    step(1, 0, 0, 0, 0);
    idle(10);
    step(0, 0, 1, 2, 7);
    idle(30);
    check("abort_pulses", exp_count - cnt0, 0);

    // Reset mid-count restores default delays
    step(1, 1, 0, 0, 0);
    idle(10);
    do_reset();
    idle(6);

    // Chained start in the expired cycle (interval 3 back at its 10 s default)
    cnt0 = exp_count;
    step(1, 0, 0, 0, 0); s = n;
    idle(24);
    step(1, 3, 0, 0, 0); s2 = n;
    check("chain_first_lat", last_exp_edge - s, 24);
    idle(44);
    check("chain_second_lat", last_exp_edge - s2, 40);
    check("chain_pulses", exp_count - cnt0, 2);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 299);
      if (r == 0) begin
        do_reset();
      end else if (r < 8) begin
        step(0, 0, 1, $urandom_range(0, 3), $urandom_range(0, 15));
      end else if (r < 30) begin
        step(1, $urandom_range(0, 3), 0, 0, 0);
      end else if (r < 33) begin
        step(1, $urandom_range(0, 3), 1, $urandom_range(0, 3), $urandom_range(0, 3));
      end else begin
        step(0, $urandom_range(0, 3), 0, $urandom_range(0, 3), $urandom_range(0, 15));
      end
    end
    idle(70);

    #2;
    started = 0;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
